// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache refill controller:
//   - state_t      : controller FSM states
//   - LINE_WORDS   : 32-bit words per cache line
//   - LINE_W       : line width in bits
//   - TAG/IDX/OFF  : bit ranges of a byte address (tag = [31:7], index = [6:4],
//                    word offset = [3:2])
// Configuration macro used by the controller: ICACHE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_REFILL = 3'd3,
    ST_FILL   = 3'd4
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;  // 128
  localparam int WC_W       = 2;

  localparam int TAG_HI = 31;
  localparam int TAG_LO = 7;
  localparam int IDX_HI = 6;
  localparam int IDX_LO = 4;
  localparam int OFF_HI = 3;
  localparam int OFF_LO = 2;

  // Word address inside a line: keep the line base, substitute the word index.
  function automatic logic [31:0] line_word_addr(input logic [31:0] addr,
                                                 input logic [WC_W-1:0] wc);
    return {addr[31:OFF_HI+1], wc, 2'b00};
  endfunction

endpackage

// File: rtl/icache_line_asm.sv
// -----------------------------------------------------------------------------
// icache_line_asm
// Collects the words of one cache line returned by memory.
// Ports:
//   clock   in   clock, rising edge
//   reset_n in   asynchronous active-low reset (counter and line to 0)
//   clear   in   restart assembly at word 0
//   we      in   store wdata into word wc, then advance wc (wraps 3 -> 0)
//   wdata   in   [31:0] word from memory
//   wc      out  [1:0] index of the next word to be written
//   line    out  [127:0] assembled line, word k in bits [32k+31:32k]
// -----------------------------------------------------------------------------
module icache_line_asm
  import icache_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              we,
  input  logic [WORD_W-1:0] wdata,
  output logic [WC_W-1:0]   wc,
  output logic [LINE_W-1:0] line
);

  logic [WC_W-1:0] r_wc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wc <= '0;
    end else if (clear) begin
      r_wc <= '0;
    end else if (we) begin
      r_wc <= r_wc + 1'b1;  // natural wrap after the last word
    end
  end

  assign wc = r_wc;

  // One register per line word; only the word selected by the counter loads.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] r_word;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_word <= '0;
        end else if (we && (r_wc == WC_W'(gi))) begin
          r_word <= wdata;
        end
      end

      assign line[gi*WORD_W +: WORD_W] = r_word;
    end
  endgenerate

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Instruction fetch controller: looks up a registered cache, and on a miss
// reads the 4-word line from memory, writes it into the cache, then retries.
// Ports:
//   clock, reset_n           clock / asynchronous active-low reset
//   fetch_req, fetch_addr    CPU request (accepted when fetch_ready=1)
//   fetch_ready              controller idle
//   instr_valid, instr       one-cycle result pulse / held instruction
//   cache_addr               lookup and fill address to the cache
//   cache_hit, cache_instr   registered cache response
//   fill_valid, fill_line    one-cycle line write to the cache
//   mem_req, mem_addr        memory word read request
//   mem_ack, mem_rdata       memory response
//   hit_count, miss_count    (ICACHE_PERF_CNT_EN only) saturating counters
// Optional feature macro: ICACHE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       cache_addr,
  input  logic              cache_hit,
  input  logic [31:0]       cache_instr,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_line,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  // The address map (tag/index/offset) and line width are fixed.
  generate
    if (LINE_WORDS != icache_pkg::LINE_WORDS || IDX_W != (IDX_HI - IDX_LO + 1)) begin : g_cfg_check
      $error("icache_refill_ctrl: only LINE_WORDS=4 and IDX_W=3 are supported");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_addr_q;
  logic [31:0]     r_instr;
  logic            r_instr_valid;

  logic            w_accept;
  logic            w_hit_done;
  logic            w_miss;
  logic            w_clear;
  logic            w_we;
  logic [WC_W-1:0] w_wc;
  logic [LINE_W-1:0] w_line;
  logic            w_unused_addr_bits;

  assign w_unused_addr_bits = ^fetch_addr[1:0];  // byte offset is ignored

  assign w_accept   = (r_state == ST_IDLE)  && fetch_req;
  assign w_hit_done = (r_state == ST_CHECK) && cache_hit;
  assign w_miss     = (r_state == ST_CHECK) && !cache_hit;
  assign w_we       = (r_state == ST_REFILL) && mem_ack;  // acks elsewhere ignored

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_addr_q      <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_instr_valid <= w_hit_done;
      if (w_accept) begin
        r_addr_q <= {fetch_addr[31:2], 2'b00};
      end
      if (w_hit_done) begin
        r_instr <= cache_instr;
      end
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req) w_state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        // Cache samples cache_addr at the end of this cycle.
        w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (cache_hit) begin
          w_state_next = ST_IDLE;
        end else begin
          w_clear      = 1'b1;
          w_state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_ack && (w_wc == WC_W'(LINE_WORDS - 1))) w_state_next = ST_FILL;
      end
      ST_FILL: begin
        w_state_next = ST_LOOKUP;  // retry the lookup on the freshly written line
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ line assembly
  icache_line_asm u_line_asm (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_clear),
    .we      (w_we),
    .wdata   (mem_rdata),
    .wc      (w_wc),
    .line    (w_line)
  );

  // ------------------------------------------------------------------ outputs
  assign fetch_ready = (r_state == ST_IDLE);
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign cache_addr  = r_addr_q;
  assign fill_valid  = (r_state == ST_FILL);
  assign fill_line   = w_line;
  assign mem_req     = (r_state == ST_REFILL);
  assign mem_addr    = (r_state == ST_REFILL) ? line_word_addr(r_addr_q, w_wc) : '0;

`ifdef ICACHE_PERF_CNT_EN
  // A retry lookup follows FILL; its hit belongs to the miss already counted.
  logic        r_retry;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retry      <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == ST_FILL) begin
        r_retry <= 1'b1;
      end else if (w_accept) begin
        r_retry <= 1'b0;
      end
      if (w_hit_done && !r_retry && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Bench for icache_refill_ctrl: a bench-owned cache and memory drive the DUT
// inputs; a transaction-level model checks outputs every cycle; directed
// scenarios pin results with literal values.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         fetch_req = 1'b0;
  logic [31:0]  fetch_addr = '0;
  logic         fetch_ready;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  cache_addr;
  logic         cache_hit = 1'b0;
  logic [31:0]  cache_instr = '0;
  logic         fill_valid;
  logic [127:0] fill_line;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache_refill_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .cache_addr  (cache_addr),
    .cache_hit   (cache_hit),
    .cache_instr (cache_instr),
    .fill_valid  (fill_valid),
    .fill_line   (fill_line),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Ground truth of instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    if (a[31:4] == 28'h0000004 && a[3:2] == 2'd0) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // ---------------------------------------------------------- cache model
  bit          c_valid [8];
  logic [24:0] c_tag   [8];
  logic [31:0] c_data  [8][4];
  logic [31:0] la = '0;

  always @(negedge clock) begin
    la = cache_addr;
    if (reset_n && fill_valid) begin
      c_valid[cache_addr[6:4]] = 1'b1;
      c_tag[cache_addr[6:4]]   = cache_addr[31:7];
      for (int k = 0; k < 4; k++) c_data[cache_addr[6:4]][k] = fill_line[32*k +: 32];
    end
  end

  always @(posedge clock) begin
    #1;
    cache_hit   = c_valid[la[6:4]] && (c_tag[la[6:4]] == la[31:7]);
    cache_instr = c_data[la[6:4]][la[3:2]];
  end

  // --------------------------------------------------------- memory model
  int ack_delay = 0;
  bit spurious  = 1'b0;
  int wait_cnt  = 0;

  always @(posedge clock) begin
    #2;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack   = spurious;
      mem_rdata = 32'hBAD0BAD0;
      wait_cnt  = 0;
    end
  end

  // ---------------------------------------------- transaction-level model
  int           cyc = 0;
  bit           busy = 1'b0;
  bit           filled = 1'b0;
  bit           prev_fill = 1'b0;
  logic [31:0]  exp_addr = '0;
  logic [31:0]  prev_instr = '0;
  int           acc_cyc = 0;
  int           last_lat = 0;
  int           n_accept = 0, n_valid = 0, n_fill = 0, n_memreq = 0;
  logic [31:0]  words[$];
  logic [31:0]  addr_log[$];
  logic [31:0]  valid_log[$];
  logic [127:0] last_line = '0;

  always @(negedge clock) begin
    logic [127:0] el;
    logic [1:0]   wi;
    cyc++;
    if (!reset_n) begin
      busy = 1'b0; filled = 1'b0; prev_fill = 1'b0;
      exp_addr = '0; prev_instr = '0; words.delete();
    end else begin
      check("excl_valid", {126'd0, instr_valid, fill_valid} & 128'd3, (fill_valid && instr_valid) ? 128'd0 : {126'd0, instr_valid, fill_valid});
      check("cache_addr", cache_addr, exp_addr);
      if (mem_req) begin
        n_memreq++;
        wi = words.size() % 4;
        check("mem_req_when", (busy && !filled && words.size() < 4) ? 1 : 0, 1);
        check("mem_addr", mem_addr, {exp_addr[31:4], wi, 2'b00});
        if (mem_ack) begin
          words.push_back(mem_rdata);
          addr_log.push_back(mem_addr);
        end
      end
      if (fill_valid) begin
        n_fill++;
        check("fill_one_cycle", prev_fill, 0);
        check("fill_words", words.size(), 4);
        for (int k = 0; k < 4; k++) el[32*k +: 32] = mem_word({exp_addr[31:4], 4'h0} + 32'(4*k));
        check("fill_line", fill_line, el);
        last_line = fill_line;
        filled    = 1'b1;
      end
      prev_fill = fill_valid;
      if (instr_valid) begin
        n_valid++;
        last_lat = cyc - acc_cyc;
        valid_log.push_back(instr);
        check("instr_when_busy", busy, 1);
        check("instr", instr, mem_word(exp_addr));
        if (!filled) check("hit_latency", last_lat, 3);
        busy = 1'b0;
      end else begin
        check("instr_hold", instr, prev_instr);
      end
      prev_instr = instr;
      check("fetch_ready", fetch_ready, !busy);
      if (fetch_req && !busy) begin
        n_accept++;
        busy     = 1'b1;
        exp_addr = {fetch_addr[31:2], 2'b00};
        acc_cyc  = cyc;
        filled   = 1'b0;
        words.delete();
      end
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic check_reset_vals(input string tag);
    check({tag, "_fetch_ready"}, fetch_ready, 1);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instr"},       instr,       0);
    check({tag, "_fill_valid"},  fill_valid,  0);
    check({tag, "_fill_line"},   fill_line,   0);
    check({tag, "_mem_req"},     mem_req,     0);
    check({tag, "_mem_addr"},    mem_addr,    0);
    check({tag, "_cache_addr"},  cache_addr,  0);
`ifdef ICACHE_PERF_CNT_EN
    check({tag, "_hit_count"},   hit_count,   0);
    check({tag, "_miss_count"},  miss_count,  0);
`endif
  endtask

  task automatic wait_count(input string nm, input int target, input int max_cyc, input int which);
    int t = 0;
    int cur;
    cur = (which == 0) ? n_accept : (which == 1) ? n_valid : addr_log.size();
    while (cur < target && t < max_cyc) begin
      @(negedge clock); #1;
      t++;
      cur = (which == 0) ? n_accept : (which == 1) ? n_valid : addr_log.size();
    end
    if (cur < target) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] a);
    int na, nv;
    na = n_accept; nv = n_valid;
    @(posedge clock); #1;
    fetch_req = 1'b1; fetch_addr = a;
    wait_count({nm, "_accept"}, na + 1, 50, 0);
    @(posedge clock); #1;
    fetch_req = 1'b0;
    wait_count({nm, "_valid"}, nv + 1, 400, 1);
    $display("[TB] %s fetch %08h -> instr %08h latency %0d", nm, a, instr, last_lat);
  endtask

  // -------------------------------------------------------------- directed
  initial begin
    int mr0, nf0, na0, nv0;
    for (int k = 0; k < 4; k++) c_data[4][k] = mem_word(32'h40 + 32'(4*k));
    c_valid[4] = 1'b1;
    c_tag[4]   = '0;

    #3 check_reset_vals("por");
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // Hit with spurious mem_ack present: 3-cycle latency, no memory traffic.
    spurious = 1'b1; mr0 = n_memreq; nf0 = n_fill;
    do_fetch("hit_40", 32'h0000_0040);
    spurious = 1'b0;
    check("hit_40_instr", instr, 32'hDEADBEEF);
    check("hit_40_lat", last_lat, 3);
    check("hit_40_no_memreq", n_memreq - mr0, 0);
    check("hit_40_no_fill", n_fill - nf0, 0);

    // Miss with an ack every cycle.
    ack_delay = 0; addr_log.delete(); nf0 = n_fill;
    do_fetch("miss_1234", 32'h0000_1234);
    check("miss_1234_nacks", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("miss_1234_a0", addr_log[0], 32'h1230);
      check("miss_1234_a1", addr_log[1], 32'h1234);
      check("miss_1234_a2", addr_log[2], 32'h1238);
      check("miss_1234_a3", addr_log[3], 32'h123C);
    end
    check("miss_1234_line", last_line, 128'h00000044_00000033_00000022_00000011);
    check("miss_1234_fills", n_fill - nf0, 1);
    check("miss_1234_instr", instr, 32'h22);

    // Miss with 5 wait cycles before each ack.
    ack_delay = 5; addr_log.delete(); mr0 = n_memreq;
    do_fetch("slow_2008", 32'h0000_2008);
    check("slow_2008_nacks", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("slow_2008_a0", addr_log[0], 32'h2000);
      check("slow_2008_a3", addr_log[3], 32'h200C);
    end
    check("slow_2008_memreq_cycles", n_memreq - mr0, 24);
    check("slow_2008_instr", instr, 32'h7A522008);

    // Reset after the second ack of a refill.
    ack_delay = 2; addr_log.delete();
    @(posedge clock); #1;
    fetch_req = 1'b1; fetch_addr = 32'h0000_3010;
    wait_count("rst_accept", n_accept + 1, 50, 0);
    @(posedge clock); #1;
    fetch_req = 1'b0;
    wait_count("rst_2acks", 2, 200, 2);
    @(posedge clock); #3;
    check("rst_pre_mem_req", mem_req, 1);
    check("rst_pre_mem_addr", mem_addr, 32'h3018);
    reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    $display("[TB] reset during refill after %0d acks", addr_log.size());
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    nf0 = n_fill;
    repeat (10) @(negedge clock);
    check("rst_no_fill", n_fill - nf0, 0);
    check("rst_idle_ready", fetch_ready, 1);

    // fetch_req held while busy with a changed address: hit then full refill.
    ack_delay = 0; addr_log.delete(); valid_log.delete();
    na0 = n_accept; nv0 = n_valid;
    @(posedge clock); #1;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0040;
    wait_count("hold_acc1", na0 + 1, 50, 0);
    @(posedge clock); #1;
    fetch_addr = 32'h0000_3010;
    wait_count("hold_acc2", na0 + 2, 50, 0);
    @(posedge clock); #1;
    fetch_req = 1'b0;
    wait_count("hold_valid", nv0 + 2, 400, 1);
    repeat (3) @(negedge clock);
    check("hold_accepts", n_accept - na0, 2);
    check("hold_nvalid", valid_log.size(), 2);
    if (valid_log.size() == 2) begin
      check("hold_instr0", valid_log[0], 32'hDEADBEEF);
      check("hold_instr1", valid_log[1], 32'h6A4A3010);
    end
    check("hold_nacks", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("hold_a0", addr_log[0], 32'h3010);
      check("hold_a3", addr_log[3], 32'h301C);
    end
    $display("[TB] held request: 2 results, refill of %0d words", addr_log.size());
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_count", hit_count, 1);
    check("perf_miss_count", miss_count, 1);
    $display("[TB] perf counters hit=%0d miss=%0d", hit_count, miss_count);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
